// File: rtl/spi_ctrl_stream_bridge.sv
// Byte-stream bridge for a single-CS SPI controller: host bytes queue in a TX FIFO that drains
// as CS bursts, and every received byte is captured into an RX FIFO popped with valid/ready.
module spi_ctrl_stream_bridge #(
   parameter  int FIFO_DEPTH       = 8,
   parameter  int MAX_BYTES_PER_CS = 1,
   localparam int CW               = $clog2(MAX_BYTES_PER_CS + 1),
   localparam int LW               = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          i_Clk,
   input  logic          i_Rst_L,
   input  logic [7:0]    i_Host_TX_Byte,
   input  logic          i_Host_TX_Valid,
   output logic          o_Host_TX_Ready,
   output logic [7:0]    o_Host_RX_Byte,
   output logic          o_Host_RX_Valid,
   input  logic          i_Host_RX_Ready,
   output logic [LW-1:0] o_TX_Level,
   output logic          o_RX_Overflow,
   input  logic          i_Clear_Ovf,
   output logic [CW-1:0] o_TX_Count,
   output logic [7:0]    o_TX_Byte,
   output logic          o_TX_DV,
   input  logic          i_TX_Ready,
   input  logic          i_RX_DV,
   input  logic [7:0]    i_RX_Byte
);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] remaining;
   logic [CW-1:0] burst_len;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [LW-1:0] tx_wptr, tx_rptr, tx_level;
   logic          tx_full, tx_empty, tx_push, tx_pop;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [LW-1:0] rx_wptr, rx_rptr;
   logic          rx_full, rx_valid, rx_push, rx_pop, rx_drop;

   // TX FIFO: the extra pointer bit distinguishes full from empty
   assign tx_level = tx_wptr - tx_rptr;
   assign tx_empty = (tx_wptr == tx_rptr);
   assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
   assign tx_push  = i_Host_TX_Valid && !tx_full;
   assign tx_pop   = (state == ST_ISSUE);

   always_ff @(posedge i_Clk) begin
      if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= i_Host_TX_Byte;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + LW'(1);
         if (tx_pop)  tx_rptr <= tx_rptr + LW'(1);
      end
   end

   assign o_TX_Level      = tx_level;
   assign o_Host_TX_Ready = !tx_full;

   // A burst only ever claims bytes already queued, so the FIFO cannot run dry mid-burst
   assign burst_len = (int'(tx_level) > MAX_BYTES_PER_CS) ? CW'(MAX_BYTES_PER_CS) : CW'(tx_level);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= ST_IDLE;
         remaining  <= '0;
         o_TX_Count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!tx_empty && i_TX_Ready) begin
                  remaining  <= burst_len;
                  o_TX_Count <= burst_len;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               remaining <= remaining - CW'(1);
               state     <= ST_HOLD;
            end
            // the controller needs a cycle to drop TX_Ready after a DV pulse
            ST_HOLD: state <= ST_WAIT;
            ST_WAIT: begin
               if (i_TX_Ready) state <= (remaining != '0) ? ST_ISSUE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_TX_DV   = tx_pop;
   assign o_TX_Byte = tx_pop ? tx_mem[tx_rptr[AW-1:0]] : 8'h00;

   a_no_underflow: assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
                                    (state == ST_ISSUE) |-> !tx_empty);

   // RX FIFO: a pop in the same cycle frees the slot for an incoming byte
   assign rx_valid = (rx_wptr != rx_rptr);
   assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
   assign rx_pop   = rx_valid && i_Host_RX_Ready;
   assign rx_push  = i_RX_DV && (!rx_full || rx_pop);
   assign rx_drop  = i_RX_DV && rx_full && !rx_pop;

   always_ff @(posedge i_Clk) begin
      if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= i_RX_Byte;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rx_wptr       <= '0;
         rx_rptr       <= '0;
         o_RX_Overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wptr <= rx_wptr + LW'(1);
         if (rx_pop)  rx_rptr <= rx_rptr + LW'(1);
         if (rx_drop)          o_RX_Overflow <= 1'b1;
         else if (i_Clear_Ovf) o_RX_Overflow <= 1'b0;
      end
   end

   assign o_Host_RX_Valid = rx_valid;
   assign o_Host_RX_Byte  = rx_valid ? rx_mem[rx_rptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_spi_ctrl_stream_bridge.sv
// Scenario bench for spi_ctrl_stream_bridge: one instance with one byte per CS (plus an SPI
// controller/peripheral loopback model) and one with four bytes per CS.
module tb_spi_ctrl_stream_bridge;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [7:0] exp_q [$];
   int         cnt_q [$];

   // instance with MAX_BYTES_PER_CS = 1
   logic [7:0] h_tx_byte, h_rx_byte, tx_byte;
   logic       h_tx_valid, h_tx_ready, h_rx_valid, h_rx_ready;
   logic [3:0] tx_level;
   logic       rx_ovf, clear_ovf, tx_dv;
   logic [0:0] tx_count;
   logic       tb_ready, tb_rx_dv, use_model;
   logic [7:0] tb_rx_byte;
   logic       c_ready, c_rx_dv;
   logic [7:0] c_rx_byte;

   // instance with MAX_BYTES_PER_CS = 4
   logic [7:0] d4_tx_byte, d4_rx_byte, d4_byte, d4_rx_in;
   logic       d4_tx_valid, d4_tx_ready, d4_rx_valid, d4_rx_rdy, d4_ovf, d4_clear;
   logic [3:0] d4_level;
   logic [2:0] d4_count;
   logic       d4_dv, d4_ready, d4_rx_dv;

   // SPI controller + peripheral loopback model
   logic       mdl_ready, mdl_rx_dv, mdl_busy, sclk;
   logic [7:0] mdl_rx_byte, ctl_sh, per_sh, per_rx, per_preload;
   logic [1:0] spi_mode;
   int         mdl_edge;

   assign c_ready   = use_model ? mdl_ready   : tb_ready;
   assign c_rx_dv   = use_model ? mdl_rx_dv   : tb_rx_dv;
   assign c_rx_byte = use_model ? mdl_rx_byte : tb_rx_byte;

   spi_ctrl_stream_bridge #(.FIFO_DEPTH(8), .MAX_BYTES_PER_CS(1)) u_dut1 (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_Host_TX_Byte(h_tx_byte), .i_Host_TX_Valid(h_tx_valid), .o_Host_TX_Ready(h_tx_ready),
      .o_Host_RX_Byte(h_rx_byte), .o_Host_RX_Valid(h_rx_valid), .i_Host_RX_Ready(h_rx_ready),
      .o_TX_Level(tx_level), .o_RX_Overflow(rx_ovf), .i_Clear_Ovf(clear_ovf),
      .o_TX_Count(tx_count), .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv), .i_TX_Ready(c_ready),
      .i_RX_DV(c_rx_dv), .i_RX_Byte(c_rx_byte));

   spi_ctrl_stream_bridge #(.FIFO_DEPTH(8), .MAX_BYTES_PER_CS(4)) u_dut4 (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_Host_TX_Byte(d4_tx_byte), .i_Host_TX_Valid(d4_tx_valid), .o_Host_TX_Ready(d4_tx_ready),
      .o_Host_RX_Byte(d4_rx_byte), .o_Host_RX_Valid(d4_rx_valid), .i_Host_RX_Ready(d4_rx_rdy),
      .o_TX_Level(d4_level), .o_RX_Overflow(d4_ovf), .i_Clear_Ovf(d4_clear),
      .o_TX_Count(d4_count), .o_TX_Byte(d4_byte), .o_TX_DV(d4_dv), .i_TX_Ready(d4_ready),
      .i_RX_DV(d4_rx_dv), .i_RX_Byte(d4_rx_in));

   // Controller exchanges 8 bits with a preloaded peripheral; sample edges follow CPHA
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_ready <= 1'b1; mdl_rx_dv <= 1'b0; mdl_busy <= 1'b0; sclk <= 1'b0; mdl_edge <= 0;
         mdl_rx_byte <= 8'h00; ctl_sh <= 8'h00; per_sh <= 8'h00; per_rx <= 8'h00;
      end else begin
         mdl_rx_dv <= 1'b0;
         if (use_model && tx_dv && !mdl_busy) begin
            mdl_busy <= 1'b1; mdl_ready <= 1'b0; mdl_edge <= 0;
            ctl_sh <= tx_byte; per_sh <= per_preload; sclk <= spi_mode[1];
         end else if (mdl_busy) begin
            if (mdl_edge < 16) begin
               sclk <= ~sclk;
               if (mdl_edge[0] == spi_mode[0]) begin
                  ctl_sh <= {ctl_sh[6:0], per_sh[7]};
                  per_sh <= {per_sh[6:0], ctl_sh[7]};
               end
               mdl_edge <= mdl_edge + 1;
            end else begin
               mdl_busy <= 1'b0; mdl_ready <= 1'b1; mdl_rx_dv <= 1'b1;
               mdl_rx_byte <= ctl_sh; per_rx <= per_sh;
            end
         end
      end
   end

   task automatic test_reset();
      int dv_seen;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (h_tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_tx_ready got %0b want 1", h_tx_ready); end
      n_cmp++; if (h_rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid got %0b want 0", h_rx_valid); end
      n_cmp++; if (h_rx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_rx_byte got %02h want 00", h_rx_byte); end
      n_cmp++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL rst_tx_dv got %0b want 0", tx_dv); end
      n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_tx_byte got %02h want 00", tx_byte); end
      n_cmp++; if (tx_count !== 1'b0) begin n_bad++; $display("FAIL rst_tx_count got %0d want 0", tx_count); end
      n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL rst_tx_level got %0d want 0", tx_level); end
      n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_rx_ovf got %0b want 0", rx_ovf); end
      n_cmp++; if ({d4_tx_ready, d4_rx_valid, d4_ovf, d4_dv} !== 4'b1000) begin n_bad++; $display("FAIL rst_d4_flags got %04b want 1000", {d4_tx_ready, d4_rx_valid, d4_ovf, d4_dv}); end
      n_cmp++; if ({d4_level, d4_count, d4_rx_byte, d4_byte} !== 23'd0) begin n_bad++; $display("FAIL rst_d4_values got %0h want 0", {d4_level, d4_count, d4_rx_byte, d4_byte}); end
      // reset again while a burst is in flight with a second byte still queued
      @(posedge clk); #1;
      rst_n = 1'b1; tb_ready = 1'b0;
      h_tx_valid = 1'b1; h_tx_byte = 8'h71;
      @(posedge clk); #1 h_tx_byte = 8'h72;
      @(posedge clk); #1 h_tx_valid = 1'b0; tb_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (tx_dv) break;
      end
      n_cmp++; if (tx_dv !== 1'b1) begin n_bad++; $display("FAIL rst_first_dv got %0b want 1", tx_dv); end
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL rst_mid_level got %0d want 0", tx_level); end
      n_cmp++; if ({h_tx_ready, tx_dv, tx_count} !== 3'b100) begin n_bad++; $display("FAIL rst_mid_ctrl got %03b want 100", {h_tx_ready, tx_dv, tx_count}); end
      @(posedge clk); #1 rst_n = 1'b1;
      dv_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (tx_dv) dv_seen++;
      end
      n_cmp++; if (dv_seen !== 0) begin n_bad++; $display("FAIL rst_no_dv got %0d pulses want 0", dv_seen); end
   endtask

   task automatic test_tx_order();
      logic [7:0] exp_b;
      tb_ready = 1'b1;
      fork
         begin
            for (int i = 1; i <= 3; i++) begin
               @(posedge clk); #1;
               h_tx_valid = 1'b1; h_tx_byte = 8'(i); exp_q.push_back(8'(i));
            end
            @(posedge clk); #1 h_tx_valid = 1'b0;
         end
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_dv) begin
               n_cmp++;
               if (exp_q.size() == 0) begin n_bad++; $display("FAIL order_extra_dv got %02h want none", tx_byte); end
               else begin
                  exp_b = exp_q.pop_front();
                  if (tx_byte !== exp_b) begin n_bad++; $display("FAIL order_byte got %02h want %02h", tx_byte, exp_b); end
               end
               n_cmp++; if (tx_count !== 1'b1) begin n_bad++; $display("FAIL order_count got %0d want 1", tx_count); end
            end
         end
      join
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL order_missing got %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_latency();
      tb_ready = 1'b1;
      @(posedge clk); #1 h_tx_valid = 1'b1; h_tx_byte = 8'h3C;
      @(posedge clk); #1 h_tx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL latency_early got %0b want 0", tx_dv); end
      @(negedge clk);
      n_cmp++; if ({tx_dv, tx_byte} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL latency_dv got %0b/%02h want 1/3c", tx_dv, tx_byte); end
      repeat (6) @(posedge clk);
   endtask

   task automatic test_burst4();
      logic [7:0] exp_b;
      int         exp_c;
      d4_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         d4_tx_valid = 1'b1; d4_tx_byte = 8'hA0 + 8'(i);
         exp_q.push_back(8'hA0 + 8'(i)); cnt_q.push_back(i < 4 ? 4 : 2);
      end
      @(posedge clk); #1 d4_tx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (d4_level !== 4'd6) begin n_bad++; $display("FAIL burst4_level got %0d want 6", d4_level); end
      @(posedge clk); #1 d4_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (d4_dv) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL burst4_extra_dv got %02h want none", d4_byte); end
            else begin
               exp_b = exp_q.pop_front(); exp_c = cnt_q.pop_front();
               if ({d4_byte, d4_count} !== {exp_b, 3'(exp_c)}) begin
                  n_bad++; $display("FAIL burst4_dv got %02h/count %0d want %02h/count %0d", d4_byte, d4_count, exp_b, exp_c);
               end
            end
         end
      end
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL burst4_missing got %0d left want 0", exp_q.size()); end
      exp_q.delete(); cnt_q.delete();
   endtask

   task automatic test_tx_full();
      logic [7:0] exp_b;
      tb_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         h_tx_valid = 1'b1; h_tx_byte = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
      end
      @(posedge clk); #1 h_tx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({h_tx_ready, tx_level} !== {1'b0, 4'd8}) begin n_bad++; $display("FAIL full_state got ready %0b level %0d want 0/8", h_tx_ready, tx_level); end
      @(posedge clk); #1 h_tx_valid = 1'b1; h_tx_byte = 8'hEE;
      @(posedge clk); #1 h_tx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (tx_level !== 4'd8) begin n_bad++; $display("FAIL full_ninth_push got level %0d want 8", tx_level); end
      @(posedge clk); #1 tb_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (tx_dv) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL full_extra_dv got %02h want none", tx_byte); end
            else begin
               exp_b = exp_q.pop_front();
               if (tx_byte !== exp_b) begin n_bad++; $display("FAIL full_drain got %02h want %02h", tx_byte, exp_b); end
            end
         end
      end
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL full_missing got %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_rx_overflow();
      logic [7:0] exp_b;
      use_model = 1'b0; h_rx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         tb_rx_dv = 1'b1; tb_rx_byte = 8'h10 + 8'(i);
         if (i < 8) exp_q.push_back(8'h10 + 8'(i));
      end
      @(posedge clk); #1 tb_rx_dv = 1'b0;
      @(negedge clk);
      n_cmp++; if ({rx_ovf, h_rx_valid, h_rx_byte} !== {2'b11, 8'h10}) begin n_bad++; $display("FAIL ovf_set got ovf %0b valid %0b head %02h want 1/1/10", rx_ovf, h_rx_valid, h_rx_byte); end
      // clear and a fresh drop in the same cycle: the drop wins
      @(posedge clk); #1 tb_rx_dv = 1'b1; tb_rx_byte = 8'h19; clear_ovf = 1'b1;
      @(posedge clk); #1 tb_rx_dv = 1'b0; clear_ovf = 1'b0;
      @(negedge clk);
      n_cmp++; if (rx_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_clear_collide got %0b want 1", rx_ovf); end
      @(posedge clk); #1 clear_ovf = 1'b1;
      @(posedge clk); #1 clear_ovf = 1'b0;
      @(negedge clk);
      n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0b want 0", rx_ovf); end
      // push and pop together while full
      @(posedge clk); #1 tb_rx_dv = 1'b1; tb_rx_byte = 8'h1A; h_rx_ready = 1'b1;
      @(negedge clk);
      exp_b = exp_q.pop_front(); exp_q.push_back(8'h1A);
      n_cmp++; if (h_rx_byte !== exp_b) begin n_bad++; $display("FAIL fullswap_head got %02h want %02h", h_rx_byte, exp_b); end
      @(posedge clk); #1 tb_rx_dv = 1'b0; h_rx_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if ({rx_ovf, h_rx_byte} !== {1'b0, exp_q[0]}) begin n_bad++; $display("FAIL fullswap_after got ovf %0b head %02h want 0/%02h", rx_ovf, h_rx_byte, exp_q[0]); end
      @(posedge clk); #1 h_rx_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (h_rx_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL rx_extra got %02h want none", h_rx_byte); end
            else begin
               exp_b = exp_q.pop_front();
               if (h_rx_byte !== exp_b) begin n_bad++; $display("FAIL rx_pop got %02h want %02h", h_rx_byte, exp_b); end
            end
         end
      end
      @(posedge clk); #1 h_rx_ready = 1'b0;
      n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL rx_missing got %0d left want 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_loopback();
      logic got;
      use_model = 1'b1; h_rx_ready = 1'b0; per_preload = 8'hC3;
      for (int m = 0; m < 4; m++) begin
         spi_mode = 2'(m);
         @(posedge clk); #1 h_tx_valid = 1'b1; h_tx_byte = 8'h5A;
         @(posedge clk); #1 h_tx_valid = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (h_rx_valid) begin got = 1'b1; break; end
         end
         n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL loop_mode%0d_timeout got no rx byte want c3", m); end
         n_cmp++; if (h_rx_byte !== 8'hC3) begin n_bad++; $display("FAIL loop_mode%0d_host_rx got %02h want c3", m, h_rx_byte); end
         n_cmp++; if (per_rx !== 8'h5A) begin n_bad++; $display("FAIL loop_mode%0d_periph_rx got %02h want 5a", m, per_rx); end
         n_cmp++; if (sclk !== spi_mode[1]) begin n_bad++; $display("FAIL loop_mode%0d_sclk_idle got %0b want %0b", m, sclk, spi_mode[1]); end
         @(posedge clk); #1 h_rx_ready = 1'b1;
         @(posedge clk); #1 h_rx_ready = 1'b0;
         repeat (4) @(posedge clk);
      end
      use_model = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      h_tx_byte = 8'h00; h_tx_valid = 1'b0; h_rx_ready = 1'b0; clear_ovf = 1'b0;
      tb_ready = 1'b1; tb_rx_dv = 1'b0; tb_rx_byte = 8'h00; use_model = 1'b0;
      per_preload = 8'h00; spi_mode = 2'd0;
      d4_tx_byte = 8'h00; d4_tx_valid = 1'b0; d4_rx_rdy = 1'b0; d4_clear = 1'b0;
      d4_ready = 1'b0; d4_rx_dv = 1'b0; d4_rx_in = 8'h00;
      test_reset();
      test_tx_order();
      test_latency();
      test_burst4();
      test_tx_full();
      test_rx_overflow();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got no finish want finish before 300000");
      $fatal(1, "watchdog expired");
   end
endmodule
